// File: rtl/sp_memory_core_if.sv
// sp_memory_core request/response bus.
// Master drives requests; slave returns read data and status.
interface sp_memory_core_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              ce_mem;
  logic              we_mem;
  logic [DATA_W/8-1:0] be_mem;
  logic [ADDR_W-1:0] addr_mem;
  logic [DATA_W-1:0] datai_mem;
  logic [DATA_W-1:0] datao_mem;
  logic              rvalid_mem;
  logic              busy_mem;
  logic              err_mem;

  modport master (
    output ce_mem, we_mem, be_mem,
    output addr_mem, datai_mem,
    input  datao_mem, rvalid_mem,
    input  busy_mem, err_mem
  );

  modport slave (
    input  ce_mem, we_mem, be_mem,
    input  addr_mem, datai_mem,
    output datao_mem, rvalid_mem,
    output busy_mem, err_mem
  );
endinterface

// File: rtl/sp_memory_core.sv
// Single-port synchronous SRAM model with byte enables,
// 1/2-cycle read latency, range check and zero-fill init.
module sp_memory_core #(
  parameter int DATA_W        = 8,
  parameter int DEPTH         = 256,
  parameter int ADDR_W        = $clog2(DEPTH),
  parameter int RD_LAT        = 1,
  parameter int INIT_ON_RESET = 1
) (
  input logic clk,
  input logic rst_n,
  sp_memory_core_if.slave bus
);

  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {INIT, READY} state_t;

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_nx;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              busy;
  logic              in_rng;
  logic              acc;
  logic              rd_fire;
  logic              wr_fire;
  logic              err_nx;
  logic [DATA_W-1:0] rd_word;

  logic              out_v;
  logic              out_oor;
  logic [DATA_W-1:0] out_d;

  logic [DATA_W-1:0] datao_q;
  logic              rvalid_q;
  logic              err_q;

  assign busy    = (state == INIT);
  assign in_rng  = {1'b0, bus.addr_mem} < DEPTH_X;
  assign acc     = bus.ce_mem & ~busy;
  assign rd_fire = acc & ~bus.we_mem;
  assign wr_fire = acc & bus.we_mem & in_rng;
  assign rd_word = in_rng ? mem[bus.addr_mem] : '0;

  // FSM state and fill-counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= (INIT_ON_RESET != 0) ? INIT : READY;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Walk the fill counter through the array, then go ready
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      INIT: begin
        cnt_nx = cnt + 1'b1;
        if (cnt == LAST) begin
          state_nx = READY;
          cnt_nx   = '0;
        end
      end
      READY: begin
        state_nx = READY;
      end
      default: begin
        state_nx = READY;
      end
    endcase
  end

  // Array: zero-fill while busy, byte-lane writes when ready
  always_ff @(posedge clk) begin
    if (busy && rst_n) begin
      mem[cnt] <= '0;
    end else if (wr_fire) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.be_mem[i])
          mem[bus.addr_mem][8*i +: 8] <= bus.datai_mem[8*i +: 8];
      end
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic              s1_v;
    logic              s1_oor;
    logic [DATA_W-1:0] s1_d;

    // Extra read register stage
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_v   <= 1'b0;
        s1_oor <= 1'b0;
        s1_d   <= '0;
      end else begin
        s1_v   <= rd_fire;
        s1_oor <= rd_fire & ~in_rng;
        if (rd_fire)
          s1_d <= rd_word;
      end
    end

    assign out_v   = s1_v;
    assign out_oor = s1_oor;
    assign out_d   = s1_d;
  end else begin : g_lat1
    assign out_v   = rd_fire;
    assign out_oor = rd_fire & ~in_rng;
    assign out_d   = rd_word;
  end

  // Dropped writes flag now; bad reads flag with their data
  assign err_nx = (bus.ce_mem & busy)
                | (acc & bus.we_mem & ~in_rng)
                | (out_v & out_oor);

  // Output registers: data holds between reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      datao_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= out_v;
      err_q    <= err_nx;
      if (out_v)
        datao_q <= out_d;
    end
  end

  assign bus.datao_mem  = datao_q;
  assign bus.rvalid_mem = rvalid_q;
  assign bus.err_mem    = err_q;
  assign bus.busy_mem   = busy;

endmodule

// File: tb/tb_sp_memory_core.sv
// Directed bench for sp_memory_core: a 32x200 RD_LAT=1
// instance (ia) and an 8x256 RD_LAT=2 instance (ib).
module tb_sp_memory_core;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  sp_memory_core_if #(.DATA_W(32), .ADDR_W(8)) ia ();
  sp_memory_core_if #(.DATA_W(8),  .ADDR_W(8)) ib ();

  sp_memory_core #(
    .DATA_W(32), .DEPTH(200), .ADDR_W(8),
    .RD_LAT(1), .INIT_ON_RESET(1)
  ) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));

  sp_memory_core #(
    .DATA_W(8), .DEPTH(256), .ADDR_W(8),
    .RD_LAT(2), .INIT_ON_RESET(1)
  ) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));

  task automatic drv_a(input bit ce, input bit we, input logic [7:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    ia.ce_mem = ce; ia.we_mem = we; ia.addr_mem = a;
    ia.datai_mem = d; ia.be_mem = be;
  endtask

  task automatic drv_b(input bit ce, input bit we, input logic [7:0] a,
                       input logic [7:0] d);
    ib.ce_mem = ce; ib.we_mem = we; ib.addr_mem = a;
    ib.datai_mem = d; ib.be_mem = 1'b1;
  endtask

  task automatic idle();
    drv_a(1'b0, 1'b0, 8'd0, 32'd0, 4'd0);
    drv_b(1'b0, 1'b0, 8'd0, 8'd0);
  endtask

  // Counts posedges after reset release until each busy drops.
  task automatic count_busy(input int pre, input bit inj,
                            output int ka, output int kb, output int stray);
    int k;
    k = pre; ka = 0; kb = 0; stray = 0;
    while ((ka == 0 || kb == 0) && k < pre + 400) begin
      @(posedge clk); #1;
      k++;
      if (ia.rvalid_mem || ib.rvalid_mem) stray++;
      if (!ia.busy_mem && ka == 0) ka = k;
      if (!ib.busy_mem && kb == 0) kb = k;
      if (inj && k == pre + 20) begin
        drv_a(1'b1, 1'b1, 8'd3, 32'h5A, 4'hF);
        drv_b(1'b1, 1'b1, 8'd3, 8'h5A);
      end
      if (inj && k == pre + 21) idle();
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (ia.busy_mem !== 1'b1) begin n_bad++; $display("FAIL rst_busy_a got=%b exp=1", ia.busy_mem); end
    n_cmp++; if (ib.busy_mem !== 1'b1) begin n_bad++; $display("FAIL rst_busy_b got=%b exp=1", ib.busy_mem); end
    n_cmp++; if (ia.rvalid_mem !== 1'b0) begin n_bad++; $display("FAIL rst_rvalid_a got=%b exp=0", ia.rvalid_mem); end
    n_cmp++; if (ib.err_mem !== 1'b0) begin n_bad++; $display("FAIL rst_err_b got=%b exp=0", ib.err_mem); end
    n_cmp++; if (ia.datao_mem !== 32'h0) begin n_bad++; $display("FAIL rst_datao_a got=%h exp=0", ia.datao_mem); end
  endtask

  task automatic test_init_fill();
    int ka, kb, st;
    logic [7:0] aa [4];
    logic [7:0] ab [4];
    aa[0] = 8'd0; aa[1] = 8'd128; aa[2] = 8'd199; aa[3] = 8'd3;
    ab[0] = 8'd0; ab[1] = 8'd128; ab[2] = 8'd255; ab[3] = 8'd3;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    drv_a(1'b1, 1'b1, 8'd3, 32'h5A, 4'hF);
    drv_b(1'b1, 1'b1, 8'd3, 8'h5A);
    @(negedge clk); idle();
    n_cmp++; if (ia.err_mem !== 1'b1) begin n_bad++; $display("FAIL busy_err_a got=%b exp=1", ia.err_mem); end
    n_cmp++; if (ib.err_mem !== 1'b1) begin n_bad++; $display("FAIL busy_err_b got=%b exp=1", ib.err_mem); end
    n_cmp++; if (ib.rvalid_mem !== 1'b0) begin n_bad++; $display("FAIL busy_rvalid_b got=%b exp=0", ib.rvalid_mem); end
    @(negedge clk);
    n_cmp++; if (ia.err_mem !== 1'b0) begin n_bad++; $display("FAIL busy_err_pulse_a got=%b exp=0", ia.err_mem); end
    count_busy(3, 1'b1, ka, kb, st);
    n_cmp++; if (ka !== 200) begin n_bad++; $display("FAIL init_cycles_a got=%0d exp=200", ka); end
    n_cmp++; if (kb !== 256) begin n_bad++; $display("FAIL init_cycles_b got=%0d exp=256", kb); end
    n_cmp++; if (st !== 0) begin n_bad++; $display("FAIL init_stray got=%0d exp=0", st); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i < 4) begin
        drv_a(1'b1, 1'b0, aa[i], 32'h0, 4'h0);
        drv_b(1'b1, 1'b0, ab[i], 8'h0);
      end else idle();
      if (i >= 1 && i <= 4) begin
        n_cmp++; if (ia.rvalid_mem !== 1'b1 || ia.datao_mem !== 32'h0) begin n_bad++; $display("FAIL fill_rd_a%0d got=%b/%h exp=1/0", i, ia.rvalid_mem, ia.datao_mem); end
      end
      if (i >= 2) begin
        n_cmp++; if (ib.rvalid_mem !== 1'b1 || ib.datao_mem !== 8'h0) begin n_bad++; $display("FAIL fill_rd_b%0d got=%b/%h exp=1/0", i, ib.rvalid_mem, ib.datao_mem); end
      end
    end
  endtask

  task automatic test_byte_enable();
    @(negedge clk); drv_a(1'b1, 1'b1, 8'd5, 32'hAABBCCDD, 4'hF);
    @(negedge clk); drv_a(1'b1, 1'b1, 8'd5, 32'h11223344, 4'h5);
    n_cmp++; if (ia.rvalid_mem !== 1'b0) begin n_bad++; $display("FAIL wr_rvalid got=%b exp=0", ia.rvalid_mem); end
    @(negedge clk); drv_a(1'b1, 1'b0, 8'd5, 32'h0, 4'h0);
    @(negedge clk); drv_a(1'b1, 1'b1, 8'd5, 32'hFFFFFFFF, 4'h0);
    n_cmp++; if (ia.rvalid_mem !== 1'b1 || ia.datao_mem !== 32'hAA22CC44) begin n_bad++; $display("FAIL be_read got=%b/%h exp=1/aa22cc44", ia.rvalid_mem, ia.datao_mem); end
    @(negedge clk); drv_a(1'b1, 1'b0, 8'd5, 32'h0, 4'h0);
    n_cmp++; if (ia.rvalid_mem !== 1'b0 || ia.datao_mem !== 32'hAA22CC44) begin n_bad++; $display("FAIL be_hold got=%b/%h exp=0/aa22cc44", ia.rvalid_mem, ia.datao_mem); end
    @(negedge clk); idle();
    n_cmp++; if (ia.datao_mem !== 32'hAA22CC44) begin n_bad++; $display("FAIL be_zero_noop got=%h exp=aa22cc44", ia.datao_mem); end
    n_cmp++; if (ia.err_mem !== 1'b0) begin n_bad++; $display("FAIL be_err got=%b exp=0", ia.err_mem); end
  endtask

  task automatic test_out_of_range();
    @(negedge clk); drv_a(1'b1, 1'b1, 8'd199, 32'h12345678, 4'hF);
    @(negedge clk); drv_a(1'b1, 1'b1, 8'd210, 32'hFFFFFFFF, 4'hF);
    @(negedge clk); drv_a(1'b1, 1'b0, 8'd199, 32'h0, 4'h0);
    n_cmp++; if (ia.err_mem !== 1'b1 || ia.rvalid_mem !== 1'b0) begin n_bad++; $display("FAIL oor_wr got=%b/%b exp=1/0", ia.err_mem, ia.rvalid_mem); end
    @(negedge clk); drv_a(1'b1, 1'b0, 8'd210, 32'h0, 4'h0);
    n_cmp++; if (ia.datao_mem !== 32'h12345678 || ia.err_mem !== 1'b0) begin n_bad++; $display("FAIL oor_last got=%h/%b exp=12345678/0", ia.datao_mem, ia.err_mem); end
    @(negedge clk); idle();
    n_cmp++; if (ia.rvalid_mem !== 1'b1 || ia.datao_mem !== 32'h0 || ia.err_mem !== 1'b1) begin n_bad++; $display("FAIL oor_rd got=%b/%h/%b exp=1/0/1", ia.rvalid_mem, ia.datao_mem, ia.err_mem); end
    @(negedge clk);
    n_cmp++; if (ia.rvalid_mem !== 1'b0 || ia.err_mem !== 1'b0) begin n_bad++; $display("FAIL oor_pulse got=%b/%b exp=0/0", ia.rvalid_mem, ia.err_mem); end
  endtask

  task automatic test_read_latency();
    @(negedge clk); drv_b(1'b1, 1'b1, 8'd1, 8'h10);
    @(negedge clk); drv_b(1'b1, 1'b1, 8'd2, 8'h20);
    @(negedge clk); drv_b(1'b1, 1'b1, 8'd3, 8'h30);
    @(negedge clk); drv_b(1'b1, 1'b0, 8'd1, 8'h0);
    @(negedge clk); drv_b(1'b1, 1'b0, 8'd2, 8'h0);
    n_cmp++; if (ib.rvalid_mem !== 1'b0) begin n_bad++; $display("FAIL lat_early got=%b exp=0", ib.rvalid_mem); end
    @(negedge clk); drv_b(1'b1, 1'b0, 8'd3, 8'h0);
    n_cmp++; if (ib.rvalid_mem !== 1'b1 || ib.datao_mem !== 8'h10) begin n_bad++; $display("FAIL lat_rd1 got=%b/%h exp=1/10", ib.rvalid_mem, ib.datao_mem); end
    @(negedge clk); idle();
    n_cmp++; if (ib.rvalid_mem !== 1'b1 || ib.datao_mem !== 8'h20) begin n_bad++; $display("FAIL lat_rd2 got=%b/%h exp=1/20", ib.rvalid_mem, ib.datao_mem); end
    @(negedge clk);
    n_cmp++; if (ib.rvalid_mem !== 1'b1 || ib.datao_mem !== 8'h30) begin n_bad++; $display("FAIL lat_rd3 got=%b/%h exp=1/30", ib.rvalid_mem, ib.datao_mem); end
    @(negedge clk);
    n_cmp++; if (ib.rvalid_mem !== 1'b0 || ib.datao_mem !== 8'h30) begin n_bad++; $display("FAIL lat_hold got=%b/%h exp=0/30", ib.rvalid_mem, ib.datao_mem); end
  endtask

  task automatic test_reset_mid();
    int ka, kb, st;
    @(negedge clk);
    drv_a(1'b1, 1'b0, 8'd5, 32'h0, 4'h0);
    drv_b(1'b1, 1'b0, 8'd1, 8'h0);
    @(posedge clk); #2 rst_n = 1'b0; #1;
    idle();
    n_cmp++; if (ia.rvalid_mem !== 1'b0 || ia.datao_mem !== 32'h0) begin n_bad++; $display("FAIL rmid_clear_a got=%b/%h exp=0/0", ia.rvalid_mem, ia.datao_mem); end
    n_cmp++; if (ib.busy_mem !== 1'b1) begin n_bad++; $display("FAIL rmid_busy_b got=%b exp=1", ib.busy_mem); end
    @(negedge clk); rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    count_busy(0, 1'b0, ka, kb, st);
    n_cmp++; if (ka !== 200) begin n_bad++; $display("FAIL rmid_cycles_a got=%0d exp=200", ka); end
    n_cmp++; if (kb !== 256) begin n_bad++; $display("FAIL rmid_cycles_b got=%0d exp=256", kb); end
    n_cmp++; if (st !== 0) begin n_bad++; $display("FAIL rmid_stray got=%0d exp=0", st); end
    @(negedge clk);
    drv_a(1'b1, 1'b0, 8'd5, 32'h0, 4'h0);
    drv_b(1'b1, 1'b0, 8'd1, 8'h0);
    @(negedge clk);
    drv_a(1'b1, 1'b0, 8'd199, 32'h0, 4'h0);
    drv_b(1'b1, 1'b0, 8'd2, 8'h0);
    n_cmp++; if (ia.rvalid_mem !== 1'b1 || ia.datao_mem !== 32'h0) begin n_bad++; $display("FAIL refill_a5 got=%b/%h exp=1/0", ia.rvalid_mem, ia.datao_mem); end
    @(negedge clk); idle();
    n_cmp++; if (ia.rvalid_mem !== 1'b1 || ia.datao_mem !== 32'h0) begin n_bad++; $display("FAIL refill_a199 got=%b/%h exp=1/0", ia.rvalid_mem, ia.datao_mem); end
    n_cmp++; if (ib.rvalid_mem !== 1'b1 || ib.datao_mem !== 8'h0) begin n_bad++; $display("FAIL refill_b1 got=%b/%h exp=1/0", ib.rvalid_mem, ib.datao_mem); end
    @(negedge clk);
    n_cmp++; if (ib.rvalid_mem !== 1'b1 || ib.datao_mem !== 8'h0) begin n_bad++; $display("FAIL refill_b2 got=%b/%h exp=1/0", ib.rvalid_mem, ib.datao_mem); end
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_init_fill();
    test_byte_enable();
    test_out_of_range();
    test_read_latency();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sp_memory_core.md
# sp_memory_core

Parametrised single-port synchronous SRAM model, the successor to the fixed 256x8 memory core. It adds configurable width and depth, per-byte write enables, a selectable read pipeline depth, a read-valid strobe, out-of-range address detection and an optional zero-fill sequence after reset. It sits behind the memory controller and is driven by the same chip-enable/write-enable/address handshake as the current core.

## Interface

Parameters:
- DATA_W, 8: data width in bits; must be a multiple of 8 and at least 8.
- DEPTH, 256: number of words; need not be a power of two.
- ADDR_W, $clog2(DEPTH): address width; must satisfy 2^ADDR_W >= DEPTH.
- RD_LAT, 1: read latency in cycles; legal values are 1 and 2.
- INIT_ON_RESET, 1: when 1, the array is zero-filled after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ce_mem  in  1  chip enable; a request is sampled when it is high.
- we_mem  in  1  1 = write, 0 = read; qualified by ce_mem.
- be_mem  in  DATA_W/8  byte write enables; bit i covers data bits [8i+7:8i]; ignored on reads.
- addr_mem  in  ADDR_W  word address.
- datai_mem  in  DATA_W  write data.
- datao_mem  out  DATA_W  read data; holds its last value between reads.
- rvalid_mem  out  1  single-cycle pulse marking new datao_mem.
- busy_mem  out  1  high while the init sequence runs; requests are not accepted.
- err_mem  out  1  single-cycle pulse on a dropped or out-of-range request.

## Operation

- **Reset values.** While rst_n is low: datao_mem = 0, rvalid_mem = 0, err_mem = 0, pipeline stages cleared, and busy_mem = INIT_ON_RESET. The array contents are not reset.
- **Control FSM.** Two states, INIT and READY.
  - Reset entry: INIT if INIT_ON_RESET = 1, otherwise READY.
  - INIT: an internal counter writes 0 to addresses 0..DEPTH-1, one word per cycle. busy_mem stays 1 for exactly DEPTH cycles after reset release, then the FSM moves to READY and busy_mem drops to 0.
  - Reset asserted mid-INIT: the sequence aborts and restarts from address 0 on release.
- **Requests while busy_mem = 1.** Every request with ce_mem = 1 is dropped. err_mem pulses in the following cycle. No rvalid_mem is produced.
- **Write** (READY, ce_mem = 1, we_mem = 1, addr_mem < DEPTH): each byte lane with its be_mem bit set takes the datai_mem lane; other lanes are unchanged. be_mem = 0 is a legal no-op. A write never changes datao_mem or rvalid_mem.
- **Read** (READY, ce_mem = 1, we_mem = 0, addr_mem < DEPTH): the word is returned per the latency in Timing, with a one-cycle rvalid_mem pulse.
- **Out-of-range address** (addr_mem >= DEPTH, READY):
  - Write: dropped; err_mem pulses the next cycle.
  - Read: returns datao_mem = 0 with a normal rvalid_mem pulse; err_mem pulses in the same cycle as that rvalid_mem.
- **Idle.** ce_mem = 0 leaves all state unchanged; datao_mem holds.

## Timing

- **RD_LAT = 1.** A read sampled at edge N updates datao_mem at edge N; rvalid_mem is high for the cycle after edge N.
- **RD_LAT = 2.** The data passes one extra register. datao_mem and rvalid_mem update at edge N+1.
- **Throughput.** One request per cycle. Back-to-back reads produce back-to-back rvalid_mem pulses with no bubbles.
- **Write then read, same address.** A write at edge N followed by a read at edge N+1 returns the newly written data.
- **Write is never combined with a read.** A same-cycle read-during-write cannot occur on a single port.
- **Reset mid-read.** In-flight read pipeline stages are discarded; no rvalid_mem appears after reset release.
- **End of init.** The first request accepted is the one sampled on the first edge at which busy_mem is already 0.

## Test plan

- **Init fill:** INIT_ON_RESET=1, DEPTH=256, release rst_n -> busy_mem high for exactly 256 cycles; reads of addresses 0, 128 and 255 then return 0 with rvalid_mem.
- **Byte enables:** DATA_W=32; write 0xAABBCCDD with be_mem=4'b1111 to address 5, then 0x11223344 with be_mem=4'b0101 -> read of address 5 returns 0xAA22CC44.
- **Read latency:** RD_LAT=2, reads of addresses 1, 2, 3 on consecutive cycles holding 0x10, 0x20, 0x30 -> rvalid_mem high for 3 consecutive cycles starting 2 edges after the first request, with data 0x10, 0x20, 0x30.
- **Out of range:** DEPTH=200, write 0xFF to address 210 -> err_mem pulse and the array is unchanged; read of address 210 -> datao_mem = 0 with rvalid_mem and err_mem in the same cycle.
- **Busy drop:** a write of 0x5A to address 3 issued during INIT -> err_mem pulse; after init completes, a read of address 3 returns 0.
- **Reset mid-operation:** assert rst_n low during INIT at address 100 and during an in-flight read -> after release, busy_mem is high again for a full DEPTH cycles and no stray rvalid_mem pulse appears.
